// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets N_REQ byte sources share one
// UART transmitter. A source may hold the grant across bytes (req_lock). A
// transmitter that never takes a byte is recovered by a timeout. A lock whose
// owner goes quiet is recovered by an idle counter.
//
// Ports:
//   wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//   req_valid/req_data/req_lock  per-requester byte, valid and keep-grant flag
//   req_ready           one-cycle accept pulse, one-hot
//   grant               one-hot current owner, zero when idle and unlocked
//   tx_data/tx_start    byte and request towards the transmitter
//   tx_clear_req        transmitter has taken the request
//   tx_busy             transmitter is shifting a frame
//   err_timeout/err_clr sticky "byte never taken" flag and its clear
module uart_tx_arbiter #(
    parameter int unsigned N_REQ            = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 65535,
    parameter int unsigned LOCK_IDLE_CYCLES = 1024
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_lock,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_clear_req,
    input  logic               tx_busy,
    output logic               err_timeout,
    input  logic               err_clr
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   req_ready_d;
    logic [N_REQ-1:0]   grant_d;
    logic [7:0]         tx_data_d;
    logic               tx_start_d;
    logic               err_d;
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]   lk_cnt_q, lk_cnt_d;
    logic               timeout_set;

    logic [7:0]         req_byte [N_REQ];
    logic [N_REQ-1:0]   eligible;
    logic               owner_valid;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;

    // Unpack the flat data bus into one byte per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_byte[g] = req_data[8*g +: 8];
    end

    // While locked only the owner may compete.
    assign owner_valid = |(req_valid & grant);
    assign eligible    = lock_q ? (req_valid & grant) : req_valid;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = IDX_W'((int'(last_q) + k) % int'(N_REQ));
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        grant_d     = grant;
        tx_data_d   = tx_data;
        tx_start_d  = tx_start;
        lock_d      = lock_q;
        last_d      = last_q;
        to_cnt_d    = '0;
        lk_cnt_d    = '0;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (!tx_busy && found) begin
                    state_d     = START;
                    req_ready_d = N_REQ'(1) << win;
                    grant_d     = N_REQ'(1) << win;
                    tx_data_d   = req_byte[win];
                    tx_start_d  = 1'b1;
                    last_d      = win;
                    lock_d      = req_lock[win];
                end else if (lock_q && !owner_valid) begin
                    // Owner went quiet while holding the lock.
                    if (lk_cnt_q == CNT_W'(LOCK_IDLE_CYCLES - 1)) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                    end else begin
                        lk_cnt_d = lk_cnt_q + CNT_W'(1);
                    end
                end
            end
            START: begin
                // An acknowledge in the timeout cycle still counts as success.
                if (tx_clear_req) begin
                    tx_start_d = 1'b0;
                    state_d    = DRAIN;
                end else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tx_start_d  = 1'b0;
                    timeout_set = 1'b1;
                    lock_d      = 1'b0;
                    grant_d     = '0;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    if (!lock_q) begin
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new timeout beats a simultaneous clear.
        err_d = timeout_set | (err_timeout & ~err_clr);
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            req_ready   <= '0;
            grant       <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            lock_q      <= 1'b0;
            last_q      <= IDX_W'(N_REQ - 1);
            to_cnt_q    <= '0;
            lk_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready   <= req_ready_d;
            grant       <= grant_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            err_timeout <= err_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            to_cnt_q    <= to_cnt_d;
            lk_cnt_q    <= lk_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with short timeout and lock-idle limits.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_clear_req;
    logic           tx_busy;
    logic           err_timeout;
    logic           err_clr;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .N_REQ            (N),
        .TIMEOUT_CYCLES   (16),
        .LOCK_IDLE_CYCLES (8)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_lock     (req_lock),
        .req_ready    (req_ready),
        .grant        (grant),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_clear_req (tx_clear_req),
        .tx_busy      (tx_busy),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte from decision to return to IDLE; transmitter acks on the
    // second START cycle and stays busy for two cycles.
    task automatic do_byte(input int w, input logic [7:0] b, input logic lck, input string tag);
        @(negedge clk);
        chk({tag, ".ready"},   32'(req_ready), 32'(1) << w);
        chk({tag, ".grant"},   32'(grant),     32'(1) << w);
        chk({tag, ".data"},    32'(tx_data),   32'(b));
        chk({tag, ".start"},   32'(tx_start),  32'd1);
        @(negedge clk);
        chk({tag, ".pulse"},   32'(req_ready), 32'd0);
        chk({tag, ".hold"},    32'(tx_start),  32'd1);
        tx_clear_req = 1'b1;
        tx_busy      = 1'b1;
        @(negedge clk);
        tx_clear_req = 1'b0;
        chk({tag, ".drop"},    32'(tx_start),  32'd0);
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        chk({tag, ".gr_end"},  32'(grant),     lck ? (32'(1) << w) : 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 4'b1111;
        req_data     = {8'h13, 8'h12, 8'h11, 8'h10};
        req_lock     = '0;
        tx_clear_req = 1'b0;
        tx_busy      = 1'b0;
        err_clr      = 1'b0;

        // Reset state; no arbitration while reset is held.
        repeat (2) @(negedge clk);
        chk("rst.start", 32'(tx_start),    32'd0);
        chk("rst.grant", 32'(grant),       32'd0);
        chk("rst.ready", 32'(req_ready),   32'd0);
        chk("rst.data",  32'(tx_data),     32'd0);
        chk("rst.err",   32'(err_timeout), 32'd0);

        // Busy transmitter blocks arbitration.
        rst     = 1'b0;
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy.start", 32'(tx_start), 32'd0);
        chk("busy.grant", 32'(grant),    32'd0);
        tx_busy = 1'b0;

        // Round robin with all requesters valid.
        do_byte(0, 8'h10, 1'b0, "rr0");
        do_byte(1, 8'h11, 1'b0, "rr1");
        do_byte(2, 8'h12, 1'b0, "rr2");
        do_byte(3, 8'h13, 1'b0, "rr3");
        do_byte(0, 8'h10, 1'b0, "rr4");

        // Locked two-byte message from requester 2 with requester 0 waiting.
        req_valid       = 4'b0101;
        req_data[23:16] = 8'h41;
        req_lock        = 4'b0100;
        do_byte(2, 8'h41, 1'b1, "lk1");
        req_data[23:16] = 8'h42;
        req_lock        = 4'b0000;
        do_byte(2, 8'h42, 1'b0, "lk2");
        req_valid       = 4'b0001;
        do_byte(0, 8'h10, 1'b0, "lk3");
        req_valid       = 4'b0000;

        // Timeout: sixteen START cycles, then error; err_clr clears it.
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h55;
        req_lock      = 4'b0001;
        @(negedge clk);
        chk("to.start",  32'(tx_start), 32'd1);
        chk("to.data",   32'(tx_data),  32'h55);
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
        repeat (15) @(negedge clk);
        chk("to.last",   32'(tx_start),    32'd1);
        chk("to.noerr",  32'(err_timeout), 32'd0);
        @(negedge clk);
        chk("to.drop",   32'(tx_start),    32'd0);
        chk("to.err",    32'(err_timeout), 32'd1);
        chk("to.grant",  32'(grant),       32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to.clr",    32'(err_timeout), 32'd0);

        // Acknowledge in the exact timeout cycle wins.
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h66;
        @(negedge clk);
        chk("race.start", 32'(tx_start), 32'd1);
        req_valid = 4'b0000;
        repeat (15) @(negedge clk);
        tx_clear_req = 1'b1;
        tx_busy      = 1'b1;
        @(negedge clk);
        tx_clear_req = 1'b0;
        tx_busy      = 1'b0;
        chk("race.drop",  32'(tx_start),    32'd0);
        chk("race.err",   32'(err_timeout), 32'd0);
        chk("race.drain", 32'(grant),       32'd1);
        @(negedge clk);
        chk("race.idle",  32'(grant),       32'd0);

        // Timeout and err_clr in the same cycle: the new error stays.
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h77;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (15) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("setwin.err", 32'(err_timeout), 32'd1);
        @(negedge clk);
        chk("setwin.sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("setwin.clr", 32'(err_timeout), 32'd0);

        // Lock-idle release: owner 2 goes quiet, requester 1 waits.
        req_valid       = 4'b0100;
        req_data[23:16] = 8'h21;
        req_data[15:8]  = 8'h31;
        req_lock        = 4'b0100;
        do_byte(2, 8'h21, 1'b1, "li");
        req_valid = 4'b0010;
        req_lock  = 4'b0000;
        repeat (7) @(negedge clk);
        chk("li.held",   32'(grant),     32'h4);
        @(negedge clk);
        chk("li.rel",    32'(grant),     32'd0);
        chk("li.wait",   32'(req_ready), 32'd0);
        @(negedge clk);
        chk("li.ready",  32'(req_ready), 32'h2);
        chk("li.grant",  32'(grant),     32'h2);
        chk("li.data",   32'(tx_data),   32'h31);

        // Reset while in START drops outputs at once; requester 0 wins next.
        #2 rst = 1'b1;
        #1;
        chk("rs.start", 32'(tx_start),  32'd0);
        chk("rs.grant", 32'(grant),     32'd0);
        chk("rs.ready", 32'(req_ready), 32'd0);
        req_valid = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rs.win",   32'(req_ready), 32'h1);
        chk("rs.wgnt",  32'(grant),     32'h1);
        chk("rs.wdat",  32'(tx_data),   32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
